hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001: clk  in  1  single clock; all state updates on posedge clk.
REQ-002: reset  in  1  synchronous, active-high reset.
REQ-003: Rs1D, Rs2D  in  5 each  source register indices of the instruction in ID.
REQ-004: Rs1E, Rs2E, RdE  in  5 each  source and destination register indices in EX.
REQ-005: ResultSrcE  in  2  EX result select; 2'b01 marks a load.
REQ-006: PCSrcE  in  1  taken branch or jump resolved in EX.
REQ-007: RdM, RdW  in  5 each; RegWriteM, RegWriteW  in  1 each  writeback info for MEM and WB.
REQ-008: MulReqE  in  1  the instruction in EX needs the multi-cycle unit; MulDoneE  in  1  the unit's result is valid.
REQ-009: ForwardAE, ForwardBE  out  2 each  EX operand select: 00 register file, 10 from MEM, 01 from WB.
REQ-010: StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-011: FlushD, FlushE, FlushM  out  1 each  bubble into IF/ID, ID/EX and EX/MEM.
REQ-012: MulStart  out  1  one-cycle start pulse to the multi-cycle unit.
REQ-013: StallCount, FlushCount  out  16 each  saturating performance counters.

Function
REQ-014: The forwarding outputs SHALL be combinational, with MEM priority:
- 10 when RegWriteM, RdM!=0 and RdM==Rs1E (or Rs2E);
- otherwise 01 when RegWriteW, RdW!=0 and RdW==Rs1E (or Rs2E);
- otherwise 00.
REQ-015: lwStall SHALL be true when ResultSrcE==01, RdE!=0 and RdE equals Rs1D or Rs2D.
REQ-016: The FSM SHALL have three states: RUN, MUL_BUSY and MUL_DONE.
REQ-017: In RUN with MulReqE=1 and PCSrcE=0, the FSM SHALL pulse MulStart for exactly that cycle, assert StallF, StallD, StallE and FlushM, and go to MUL_BUSY.
REQ-018: In MUL_BUSY, StallF, StallD, StallE and FlushM SHALL stay 1 and MulStart SHALL stay 0.
- MulDoneE=1 SHALL move the FSM to MUL_DONE in the next cycle.
- MulDoneE=0 SHALL keep the FSM in MUL_BUSY with no timeout.
REQ-019: MUL_DONE SHALL last exactly one cycle with all stalls and flushes deasserted, so the EX instruction advances; MulReqE SHALL be ignored in it; the next state SHALL be RUN.
REQ-020: In RUN, lwStall SHALL assert StallF, StallD and FlushE; StallE and FlushM SHALL stay 0.
REQ-021: In RUN, PCSrcE SHALL assert FlushD and FlushE.
REQ-022: When PCSrcE and lwStall are both true, PCSrcE SHALL win: StallF and StallD at 0, FlushD and FlushE at 1.
REQ-023: When PCSrcE and MulReqE are both true in RUN, PCSrcE SHALL win and no multi-cycle operation starts.
REQ-024: lwStall and PCSrcE SHALL be ignored in MUL_BUSY; FlushD and FlushE SHALL be 0 there.
REQ-025: StallCount SHALL increment in each cycle with StallF=1 and saturate at 16'hFFFF.
REQ-026: FlushCount SHALL increment in each cycle with FlushE=1 and saturate at 16'hFFFF.
REQ-027: All stall, flush and MulStart outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.

Reset
REQ-028: With reset=1 at posedge clk, the FSM SHALL go to RUN and both counters SHALL be set to 0.
REQ-029: With reset held, the outputs SHALL be: all stalls 0, FlushM 0, MulStart 0.
- Forward, FlushD and FlushE outputs SHALL follow the combinational rules in REQ-014, REQ-020 and REQ-021.
REQ-030: Reset asserted in MUL_BUSY or MUL_DONE SHALL abandon the operation: RUN on the next cycle and no further MulStart.

Structure
REQ-031: Package hazard_pkg SHALL hold:
- the state enum (RUN, MUL_BUSY, MUL_DONE);
- forward select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10;
- RESULT_SRC_LOAD=2'b01;
- COUNT_W=16.
REQ-032: Forwarding logic SHALL be one sub-module, forward_unit, instantiated once per operand.

Verification
REQ-033: Forwarding scenario SHALL cover:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10;
- RdM=0 with the same W values -> ForwardAE=01;
- Rs1E=0 -> 00.
REQ-034: Load-use scenario: ResultSrcE=01, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 that cycle and StallCount +1.
REQ-035: Multi-cycle scenario: MulReqE=1 in RUN, MulDoneE after 4 busy cycles -> pattern below, then RUN.
- MulStart one cycle;
- StallE=1 for 5 cycles total;
- one MUL_DONE cycle with no stalls.
REQ-036: Priority scenario: PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=0; PCSrcE=1 with MulReqE=1 -> MulStart=0.
REQ-037: Saturation scenario: lwStall forced for 70000 cycles -> StallCount stops at 16'hFFFF.
REQ-038: Reset scenario: reset asserted during the 2nd MUL_BUSY cycle -> RUN next cycle, all stalls 0, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a; holds the FSM state type, forward selects, load marker, counter width.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_e;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ResultSrcE encoding that identifies a load in EX
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam int COUNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one EX source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports rs_i (EX source), rd_m_i/reg_write_m_i, rd_w_i/reg_write_w_i -> fwd_o.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // MEM is checked first: it holds the younger, more recent write.
    // x0 is never forwarded since writes to it are discarded.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, multi-cycle unit sequencing.
// Latency: all stall/flush/forward/MulStart outputs are combinational (zero cycles); counters update on posedge clk.
// Backpressure: a multi-cycle op freezes F/D/E and bubbles MEM until MulDoneE; branches override load-use stalls.
module hazard_controller
    import hazard_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    input  logic [4:0]         Rs1E,
    input  logic [4:0]         Rs2E,
    input  logic [4:0]         RdE,
    input  logic [1:0]         ResultSrcE,
    input  logic               PCSrcE,
    input  logic [4:0]         RdM,
    input  logic [4:0]         RdW,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               MulReqE,
    input  logic               MulDoneE,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushM,
    output logic               MulStart,
    output logic [COUNT_W-1:0] StallCount,
    output logic [COUNT_W-1:0] FlushCount
);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   stall_cnt_q;
    logic [COUNT_W-1:0]   flush_cnt_q;
    logic                 lw_stall;

    forward_unit u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardBE)
    );

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d  = state_q;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        MulStart = 1'b0;
        if (reset) begin
            // Stalls and the multi-cycle handshake are suppressed in reset,
            // but the D/E bubbles still reflect the current hazards.
            FlushD  = PCSrcE;
            FlushE  = PCSrcE | lw_stall;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    // A taken branch squashes the younger instructions, so it
                    // outranks both a load-use stall and a multi-cycle start.
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (MulReqE) begin
                        MulStart = 1'b1;
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        StallE   = 1'b1;
                        FlushM   = 1'b1;
                        state_d  = MUL_BUSY;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    if (MulDoneE) begin
                        state_d = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    // Single release cycle: the finished op leaves EX. MulReqE
                    // still reflects that op, so it must not retrigger here.
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (StallF) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (FlushE) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule
